multicycle_datapath_control: RTL and testbench

//  Multi-cycle sequencer for the register-file / ALU / data-memory datapath. It accepts one
//  32-bit MIPS instruction per valid/ready handshake and latches it. It walks the instruction

---
 rtl/multicycle_datapath_control_pkg.sv | 29 ++
 rtl/multicycle_datapath_control_mem_watchdog.sv | 33 +++
 rtl/multicycle_datapath_control.sv | 162 ++++++++++++++++
 tb/tb_multicycle_datapath_control.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_datapath_control_pkg.sv
// Shared definitions for the multi-cycle datapath sequencer: MIPS opcodes,
// ALUOp encodings, controller states and an opcode legality helper.
package multicycle_datapath_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_e;

   // True for the five opcodes the datapath can execute.
   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/multicycle_datapath_control_mem_watchdog.sv
// Memory-stall watchdog: counts MEM cycles spent waiting for mem_ready and
// flags the cycle in which the wait budget is used up.
module mem_watchdog #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clock,
   input  logic reset_n,
   input  logic run,
   input  logic clear,
   output logic expired
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;

   // Wait counter: cleared whenever the controller is not staying in MEM.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!reset_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (run) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign expired = run && (count_q == LAST);

endmodule

// File: rtl/multicycle_datapath_control.sv
// Multi-cycle sequencer for the register-file / ALU / data-memory datapath.
// Accepts one instruction per valid/ready handshake and walks it through
// DECODE/EXEC/MEM/WB, driving the datapath controls as Moore outputs.
module multicycle_datapath_control
   import multicycle_datapath_control_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   input  logic        mem_ready,
   input  logic        zero,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] immediate,
   output logic [5:0]  FuncCode,
   output logic        RegDst,
   output logic        ALUSrc,
   output logic [1:0]  ALUOp,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemToReg,
   output logic        RegWrite,
   output logic        branch_taken,
   output logic        done,
   output logic        error
);

   state_e      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [5:0]  opcode;
   logic        accept;
   logic        is_r, is_lw, is_sw, is_beq, is_addi;
   logic        wd_run, wd_clear, wd_expired;

   assign opcode  = instr_q[31:26];
   assign is_r    = (opcode == OP_RTYPE);
   assign is_lw   = (opcode == OP_LW);
   assign is_sw   = (opcode == OP_SW);
   assign is_beq  = (opcode == OP_BEQ);
   assign is_addi = (opcode == OP_ADDI);

   assign instr_ready = (state_q == IDLE);
   assign accept      = instr_valid && instr_ready;
   assign instr_d     = accept ? instr : instr_q;

   // Field outputs always reflect the latched instruction.
   assign rs        = instr_q[25:21];
   assign rt        = instr_q[20:16];
   assign rd        = instr_q[15:11];
   assign immediate = instr_q[15:0];
   assign FuncCode  = instr_q[5:0];

   // The watchdog only runs while stalled in MEM and is cleared on any exit.
   assign wd_run   = (state_q == MEM) && !mem_ready;
   assign wd_clear = (state_d != MEM);

   mem_watchdog #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_mem_watchdog (
      .clock  (clock),
      .reset_n(reset_n),
      .run    (wd_run),
      .clear  (wd_clear),
      .expired(wd_expired)
   );

   // State and instruction registers.
   always_ff @(posedge clock) begin
      // NOTE: the instruction register is reset because its fields drive
      // outputs directly and must read 0 after reset.
      if (!reset_n) begin
         state_q <= IDLE;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
      end
   end

   // Next-state and Moore control decode; ALU selects are held from EXEC
   // through WB so the datapath muxes do not glitch between stages.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      RegDst       = 1'b0;
      ALUSrc       = 1'b0;
      ALUOp        = ALUOP_ADD;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      MemToReg     = 1'b0;
      RegWrite     = 1'b0;
      branch_taken = 1'b0;
      done         = 1'b0;
      error        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) state_d = DECODE;
         end

         DECODE: begin
            if (is_legal_op(opcode)) begin
               state_d = EXEC;
            end else begin
               state_d = IDLE;
               error   = 1'b1;
            end
         end

         EXEC: begin
            if (is_r) begin
               state_d = WB;
               RegDst  = 1'b1;
               ALUOp   = ALUOP_FUNC;
            end else if (is_addi) begin
               state_d = WB;
               ALUSrc  = 1'b1;
            end else if (is_lw || is_sw) begin
               state_d = MEM;
               ALUSrc  = 1'b1;
            end else begin
               state_d      = IDLE;
               ALUOp        = ALUOP_SUB;
               branch_taken = zero;
               done         = 1'b1;
            end
         end

         MEM: begin
            ALUSrc   = 1'b1;
            MemRead  = is_lw;
            MemWrite = is_sw;
            if (mem_ready) begin
               state_d = is_lw ? WB : IDLE;
               done    = is_sw;
            end else if (wd_expired) begin
               state_d = IDLE;
               error   = 1'b1;
            end
         end

         WB: begin
            state_d  = IDLE;
            RegWrite = 1'b1;
            done     = 1'b1;
            RegDst   = is_r;
            MemToReg = is_lw;
            ALUSrc   = is_lw || is_addi;
            ALUOp    = is_r ? ALUOP_FUNC : ALUOP_ADD;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_datapath_control.sv
// Self-checking bench for multicycle_datapath_control: a vector table of
// single instructions with a scoreboard of expected outcomes, plus hand
// sequences for reset-in-MEM and back-to-back handshakes.
module tb_multicycle_datapath_control;

   logic        clock;
   logic        reset_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic        mem_ready;
   logic        zero;
   logic [4:0]  rs, rt, rd;
   logic [15:0] immediate;
   logic [5:0]  FuncCode;
   logic        RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite;
   logic [1:0]  ALUOp;
   logic        branch_taken, done, error;

   int checks = 0;
   int errors = 0;

   multicycle_datapath_control #(
      .MEM_TIMEOUT(16)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .mem_ready   (mem_ready),
      .zero        (zero),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .immediate   (immediate),
      .FuncCode    (FuncCode),
      .RegDst      (RegDst),
      .ALUSrc      (ALUSrc),
      .ALUOp       (ALUOp),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemToReg    (MemToReg),
      .RegWrite    (RegWrite),
      .branch_taken(branch_taken),
      .done        (done),
      .error       (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        zero;
      int          wait_cyc;   // MEM cycles with mem_ready low before it rises
      int          exp_end;    // cycle (after handshake) of done or error
      int          exp_done;
      int          exp_err;
      int          exp_br;     // cycles with branch_taken
      int          exp_rw;     // cycles with RegWrite
      int          exp_mr;     // cycles with MemRead
      int          exp_mw;     // cycles with MemWrite
      int          exp_mtr;    // cycles with MemToReg
      logic [1:0]  exp_aluop;  // in EXEC
      logic        exp_regdst; // in EXEC
      logic        exp_alusrc; // in EXEC
      int          legal;
   } vec_t;

   vec_t vecs[12];
   vec_t sb_q[$];

   function automatic vec_t mk(string name, logic [31:0] ins, logic z, int w,
                               int e_end, int e_done, int e_err, int e_br,
                               int e_rw, int e_mr, int e_mw, int e_mtr,
                               logic [1:0] e_op, logic e_rd, logic e_src,
                               int lg);
      vec_t v;
      v.name = name; v.instr = ins; v.zero = z; v.wait_cyc = w;
      v.exp_end = e_end; v.exp_done = e_done; v.exp_err = e_err;
      v.exp_br = e_br; v.exp_rw = e_rw; v.exp_mr = e_mr; v.exp_mw = e_mw;
      v.exp_mtr = e_mtr; v.exp_aluop = e_op; v.exp_regdst = e_rd;
      v.exp_alusrc = e_src; v.legal = lg;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] ctl_vec();
      return {RegDst, ALUSrc, ALUOp, MemRead, MemWrite, MemToReg, RegWrite,
              branch_taken, done, error};
   endfunction

   // Drive one instruction through a handshake, monitor it to retirement and
   // compare against the scoreboard entry pushed at the handshake.
   task automatic run_vec(input vec_t v);
      vec_t e;
      int   c, n, end_c, br, rw, mr, mw, mtr, both;
      bit   ended, saw_done, saw_err;
      @(negedge clock);
      instr = v.instr; zero = v.zero; instr_valid = 1'b1; mem_ready = 1'b0;
      n = 0;
      while (!instr_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      check({v.name, "_ready_before"}, 32'(instr_ready), 32'd1);
      @(posedge clock);
      sb_q.push_back(v);
      #1;
      instr_valid = 1'b0;
      instr = 32'hDEAD_BEEF;   // must not be picked up outside IDLE
      c = 1; ended = 0; end_c = -1; saw_done = 0; saw_err = 0;
      br = 0; rw = 0; mr = 0; mw = 0; mtr = 0; both = 0;
      while (!ended && c <= 40) begin
         mem_ready = (c >= 3 + v.wait_cyc);
         @(negedge clock);
         if (branch_taken) br++;
         if (RegWrite) rw++;
         if (MemRead) mr++;
         if (MemWrite) mw++;
         if (MemToReg) mtr++;
         if (RegWrite && MemWrite) both++;
         if (c == 1) begin
            check({v.name, "_ready_drop"}, 32'(instr_ready), 32'd0);
            check({v.name, "_rd"}, 32'(rd), 32'(v.instr[15:11]));
            check({v.name, "_imm"}, 32'(immediate), 32'(v.instr[15:0]));
         end
         if (c == 2 && v.legal != 0) begin
            check({v.name, "_exec_aluop"}, 32'(ALUOp), 32'(v.exp_aluop));
            check({v.name, "_exec_regdst"}, 32'(RegDst), 32'(v.exp_regdst));
            check({v.name, "_exec_alusrc"}, 32'(ALUSrc), 32'(v.exp_alusrc));
         end
         if (done || error) begin
            ended = 1; end_c = c; saw_done = done; saw_err = error;
         end else begin
            @(posedge clock);
            #1;
            c++;
         end
      end
      check({v.name, "_retired_in_budget"}, 32'(ended), 32'd1);
      if (sb_q.size() == 0) begin
         check({v.name, "_scoreboard_entry"}, 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         check({e.name, "_end_cycle"}, 32'(end_c), 32'(e.exp_end));
         check({e.name, "_done"}, 32'(saw_done), 32'(e.exp_done));
         check({e.name, "_error"}, 32'(saw_err), 32'(e.exp_err));
         check({e.name, "_branch_cycles"}, 32'(br), 32'(e.exp_br));
         check({e.name, "_regwrite_cycles"}, 32'(rw), 32'(e.exp_rw));
         check({e.name, "_memread_cycles"}, 32'(mr), 32'(e.exp_mr));
         check({e.name, "_memwrite_cycles"}, 32'(mw), 32'(e.exp_mw));
         check({e.name, "_memtoreg_cycles"}, 32'(mtr), 32'(e.exp_mtr));
         check({e.name, "_rw_mw_overlap"}, 32'(both), 32'd0);
      end
      @(posedge clock);
      #1;
      mem_ready = 1'b0;
      @(negedge clock);
      check({v.name, "_ready_after"}, 32'(instr_ready), 32'd1);
      check({v.name, "_idle_controls"}, 32'(ctl_vec()), 32'd0);
   endtask

   // Reset while lw stalls in MEM, then back-to-back instructions with
   // instr_valid held high.
   task automatic reset_and_back_to_back();
      int rw, n, c;
      bit seen;
      @(negedge clock);
      instr = 32'h8D09_0004; instr_valid = 1'b1; mem_ready = 1'b0; zero = 1'b0;
      @(posedge clock);
      #1;
      instr_valid = 1'b0;
      rw = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         if (RegWrite) rw++;
      end
      check("rst_mem_memread_before_reset", 32'(MemRead), 32'd1);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      @(negedge clock);
      if (RegWrite) rw++;
      check("rst_mem_controls_zero", 32'(ctl_vec()), 32'd0);
      check("rst_mem_ready", 32'(instr_ready), 32'd1);
      check("rst_mem_fields_zero", {rs, rt, immediate, 6'd0}, 32'd0);
      check("rst_mem_no_regwrite", 32'(rw), 32'd0);

      // Back-to-back: R-type first, addi presented while the R-type is busy.
      reset_n = 1'b1;
      instr = 32'h012A_4020; instr_valid = 1'b1;
      @(posedge clock);
      #1;
      instr = 32'h2128_0005;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         check($sformatf("b2b_busy_ready_c%0d", k), 32'(instr_ready), 32'd0);
      end
      check("b2b_first_done", 32'(done), 32'd1);
      check("b2b_first_regwrite", 32'(RegWrite), 32'd1);
      check("b2b_first_rd_kept", 32'(rd), 32'd8);
      @(negedge clock);
      check("b2b_ready_again", 32'(instr_ready), 32'd1);
      @(posedge clock);
      #1;
      instr_valid = 1'b0;
      @(negedge clock);
      check("b2b_second_rs", 32'(rs), 32'd9);
      check("b2b_second_rt", 32'(rt), 32'd8);
      check("b2b_second_imm", 32'(immediate), 32'd5);
      c = 1; n = 0; seen = 0;
      while (!seen && n < 10) begin
         if (done) seen = 1;
         else begin
            @(negedge clock);
            c++;
            n++;
         end
      end
      check("b2b_second_done_cycle", 32'(c), 32'd3);
      check("b2b_second_regdst_wb", 32'(RegDst), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit actual=expired required=finish");
      $fatal(1);
   end

   initial begin
      //            name         instr          z  w    end dn er br rw mr  mw  mtr op     rdst src lg
      vecs[0]  = mk("r_add",     32'h012A4020, 0, 0,    3, 1, 0, 0, 1, 0,  0,  0, 2'b10, 1, 0, 1);
      vecs[1]  = mk("lw_w2",     32'h8D090004, 0, 2,    6, 1, 0, 0, 1, 3,  0,  1, 2'b00, 0, 1, 1);
      vecs[2]  = mk("beq_z1",    32'h11090003, 1, 0,    2, 1, 0, 1, 0, 0,  0,  0, 2'b01, 0, 0, 1);
      vecs[3]  = mk("beq_z0",    32'h11090003, 0, 0,    2, 1, 0, 0, 0, 0,  0,  0, 2'b01, 0, 0, 1);
      vecs[4]  = mk("sw_w0",     32'hAD090008, 0, 0,    3, 1, 0, 0, 0, 0,  1,  0, 2'b00, 0, 1, 1);
      vecs[5]  = mk("sw_w3",     32'hAD090008, 0, 3,    6, 1, 0, 0, 0, 0,  4,  0, 2'b00, 0, 1, 1);
      vecs[6]  = mk("sw_timeout",32'hAD090008, 0, 100, 18, 0, 1, 0, 0, 0, 16,  0, 2'b00, 0, 1, 1);
      vecs[7]  = mk("addi",      32'h21280005, 0, 0,    3, 1, 0, 0, 1, 0,  0,  0, 2'b00, 0, 1, 1);
      vecs[8]  = mk("illegal",   32'hFC000000, 0, 0,    1, 0, 1, 0, 0, 0,  0,  0, 2'b00, 0, 0, 0);
      vecs[9]  = mk("lw_w15",    32'h8D090004, 0, 15,  19, 1, 0, 0, 1, 16, 0,  1, 2'b00, 0, 1, 1);
      vecs[10] = mk("sw_w15",    32'hAD090008, 0, 15,  18, 1, 0, 0, 0, 0, 16,  0, 2'b00, 0, 1, 1);
      vecs[11] = mk("lw_w0",     32'h8D090004, 0, 0,    4, 1, 0, 0, 1, 1,  0,  1, 2'b00, 0, 1, 1);

      reset_n = 1'b0; instr_valid = 1'b0; instr = '0; mem_ready = 1'b0; zero = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_ready", 32'(instr_ready), 32'd1);
      check("reset_controls", 32'(ctl_vec()), 32'd0);
      check("reset_fields", {rd, immediate, FuncCode, 5'd0}, 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) run_vec(vecs[i]);

      reset_and_back_to_back();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
